// File: rtl/ladybird_config.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | ladybird_config                                                      |
// | Bus widths, ACLINT aperture base and register offsets.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ladybird_config;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = BUS_DATA_W / 8;

  localparam logic [31:0] ACLINT_MSIP_BASE = 32'h0200_0000;

  localparam logic [15:0] ACLINT_OFF_MSIP        = 16'h0000;
  localparam logic [15:0] ACLINT_OFF_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] ACLINT_OFF_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] ACLINT_OFF_SETSSIP     = 16'h8000;
  localparam logic [15:0] ACLINT_OFF_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] ACLINT_OFF_MTIME_HI    = 16'hBFFC;

  // Byte-lane merge: lanes with strb set take wdata, others keep old.
  function automatic logic [BUS_DATA_W-1:0] strb_merge(
    input logic [BUS_DATA_W-1:0] old,
    input logic [BUS_DATA_W-1:0] wdata,
    input logic [BUS_STRB_W-1:0] strb
  );
    logic [BUS_DATA_W-1:0] merged;
    merged = old;
    for (int i = 0; i < BUS_STRB_W; i++) begin
      if (strb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ladybird_aclint_mtime.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | ladybird_aclint_mtime                                                |
// | Tick prescaler and 64-bit mtime counter with byte-strobed writes.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ladybird_aclint_mtime
  import ladybird_config::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_lo,
  input  logic                  wr_hi,
  input  logic [BUS_DATA_W-1:0] wdata,
  input  logic [BUS_STRB_W-1:0] strb,
  output logic [63:0]           mtime
);

  localparam logic [31:0] c_presc_max = 32'(TICK_DIV - 1);

  logic [31:0] r_presc;
  logic [63:0] r_mtime;
  logic        w_tick;

  assign w_tick = (r_presc == c_presc_max);
  assign mtime  = r_mtime;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_mtime <= '0;
    end else begin
      r_presc <= w_tick ? 32'd0 : r_presc + 32'd1;
      // A software write takes priority and swallows this cycle's tick.
      if (wr_lo) begin
        r_mtime[31:0] <= strb_merge(r_mtime[31:0], wdata, strb);
      end else if (wr_hi) begin
        r_mtime[63:32] <= strb_merge(r_mtime[63:32], wdata, strb);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ladybird_aclint.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | ladybird_aclint                                                      |
// | ACLINT slice: MSIP, MTIMECMP, SETSSIP and MTIME behind a req/resp    |
// | port. Rev 1.0                                                        |
// +----------------------------------------------------------------------+
module ladybird_aclint
  import ladybird_config::*;
#(
  parameter logic [31:0] BASE_ADDR = ACLINT_MSIP_BASE,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BUS_ADDR_W-1:0] req_addr,
  input  logic                  req_write,
  input  logic [BUS_DATA_W-1:0] req_wdata,
  input  logic [BUS_STRB_W-1:0] req_strb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BUS_DATA_W-1:0] resp_data,
  output logic                  resp_error,
  output logic                  irq_msip,
  output logic                  irq_mtip,
  output logic                  irq_ssip_set,
  output logic [63:0]           mtime
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_resp = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic                  w_accept;
  logic [15:0]           w_off;
  logic                  w_base_hit;
  logic                  w_sel_msip, w_sel_cmp_lo, w_sel_cmp_hi;
  logic                  w_sel_ssip, w_sel_mt_lo, w_sel_mt_hi;
  logic                  w_mapped;
  logic                  w_wr;
  logic                  w_ssip_fire;
  logic [BUS_DATA_W-1:0] w_rdata;
  logic [63:0]           w_mtime;
  logic                  w_unused_ok;

  logic                  r_msip;
  logic [63:0]           r_mtimecmp;
  logic [BUS_DATA_W-1:0] r_resp_data;
  logic                  r_resp_error;
  logic                  r_ssip;

  // Word aligned: the two low address bits never select anything.
  assign w_off       = {req_addr[15:2], 2'b00};
  assign w_unused_ok = ^req_addr[1:0];
  assign w_base_hit  = (req_addr[31:16] == BASE_ADDR[31:16]);

  assign w_sel_msip   = w_base_hit && (w_off == ACLINT_OFF_MSIP);
  assign w_sel_cmp_lo = w_base_hit && (w_off == ACLINT_OFF_MTIMECMP_LO);
  assign w_sel_cmp_hi = w_base_hit && (w_off == ACLINT_OFF_MTIMECMP_HI);
  assign w_sel_ssip   = w_base_hit && (w_off == ACLINT_OFF_SETSSIP);
  assign w_sel_mt_lo  = w_base_hit && (w_off == ACLINT_OFF_MTIME_LO);
  assign w_sel_mt_hi  = w_base_hit && (w_off == ACLINT_OFF_MTIME_HI);
  assign w_mapped     = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi |
                        w_sel_ssip | w_sel_mt_lo  | w_sel_mt_hi;

  assign w_accept    = req_valid && req_ready;
  assign w_wr        = w_accept && req_write;
  assign w_ssip_fire = w_wr && w_sel_ssip && req_strb[0] && req_wdata[0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_accept)   w_state_nxt = c_st_resp;
      c_st_resp: if (resp_ready) w_state_nxt = c_st_idle;
      default:                   w_state_nxt = c_st_idle;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      c_st_idle: req_ready  = 1'b1;
      c_st_resp: resp_valid = 1'b1;
      default:   req_ready  = 1'b0;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    if (!req_write) begin
      if (w_sel_msip)   w_rdata = {{(BUS_DATA_W-1){1'b0}}, r_msip};
      if (w_sel_cmp_lo) w_rdata = r_mtimecmp[31:0];
      if (w_sel_cmp_hi) w_rdata = r_mtimecmp[63:32];
      if (w_sel_mt_lo)  w_rdata = w_mtime[31:0];
      if (w_sel_mt_hi)  w_rdata = w_mtime[63:32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msip       <= 1'b0;
      r_mtimecmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
      r_ssip       <= 1'b0;
    end else begin
      r_ssip <= w_ssip_fire;
      if (w_accept) begin
        r_resp_data  <= w_rdata;
        r_resp_error <= !w_mapped;
      end
      if (w_wr && w_sel_msip && req_strb[0]) r_msip <= req_wdata[0];
      if (w_wr && w_sel_cmp_lo)
        r_mtimecmp[31:0] <= strb_merge(r_mtimecmp[31:0], req_wdata, req_strb);
      if (w_wr && w_sel_cmp_hi)
        r_mtimecmp[63:32] <= strb_merge(r_mtimecmp[63:32], req_wdata, req_strb);
    end
  end

  ladybird_aclint_mtime #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clk   (clk),
    .rst   (rst),
    .wr_lo (w_wr && w_sel_mt_lo),
    .wr_hi (w_wr && w_sel_mt_hi),
    .wdata (req_wdata),
    .strb  (req_strb),
    .mtime (w_mtime)
  );

  assign resp_data    = r_resp_data;
  assign resp_error   = r_resp_error;
  assign irq_msip     = r_msip;
  assign irq_mtip     = (w_mtime >= r_mtimecmp);
  assign irq_ssip_set = r_ssip;
  assign mtime        = w_mtime;

endmodule
`default_nettype wire

// File: tb/tb_ladybird_aclint.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ladybird_aclint                                                   |
// | Scoreboarded bench for the ACLINT slice. Rev 1.0                     |
// +----------------------------------------------------------------------+
module tb_ladybird_aclint;
  import ladybird_config::*;

  localparam logic [31:0] c_base = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        irq_msip;
  logic        irq_mtip;
  logic        irq_ssip_set;
  logic [63:0] mtime;

  int          r_vectors = 0;
  int          r_miscompares = 0;
  logic [32:0] sb_q[$];
  logic [63:0] snap_accept;
  logic [63:0] snap_done;
  int          ssip_cnt = 0;

  always #5 clk = ~clk;

  ladybird_aclint #(
    .BASE_ADDR (c_base),
    .TICK_DIV  (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_wdata    (req_wdata),
    .req_strb     (req_strb),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_error   (resp_error),
    .irq_msip     (irq_msip),
    .irq_mtip     (irq_mtip),
    .irq_ssip_set (irq_ssip_set),
    .mtime        (mtime)
  );

  always @(negedge clk) if (irq_ssip_set) ssip_cnt <= ssip_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    r_vectors++;
    if (obs !== exp) begin
      r_miscompares++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] exp_d, input logic exp_e, input int hold);
    logic [32:0] e;
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd; req_strb = st;
    sb_q.push_back({exp_e, exp_d});
    @(posedge clk); #1;
    snap_accept = mtime;
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0; req_strb = '0;
    resp_ready = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    e = sb_q.pop_front();
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_data"}, 64'(resp_data), 64'(e[31:0]));
    chk({tag, "_err"}, 64'(resp_error), 64'(e[32]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_data"}, 64'(resp_data), 64'(e[31:0]));
      chk({tag, "_hold_rdy"}, 64'(req_ready), 64'd0);
      chk({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    snap_done = mtime;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_data"}, 64'(resp_data), 64'd0);
    chk({tag, "_resp_error"}, 64'(resp_error), 64'd0);
    chk({tag, "_msip"}, 64'(irq_msip), 64'd0);
    chk({tag, "_mtip"}, 64'(irq_mtip), 64'd0);
    chk({tag, "_ssip"}, 64'(irq_ssip_set), 64'd0);
    chk({tag, "_mtime"}, mtime, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] prev;
    logic        seen;
    int          c0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;

    // MSIP
    access("msip_wr", c_base, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 0);
    chk("msip_irq", 64'(irq_msip), 64'd1);
    access("msip_rd", c_base, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0, 0);
    access("msip_rd_lowbits", c_base + 32'h3, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0, 0);

    // Timer compare
    access("cmphi0", c_base + 32'h4004, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 0);
    access("mtlo0", c_base + 32'hBFF8, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 0);
    chk("mtlo0_snap", snap_accept, 64'd0);
    chk("mtlo0_tick", snap_done, 64'd1);
    access("cmplo10", c_base + 32'h4000, 1'b1, 32'h10, 4'hF, 32'h0, 1'b0, 0);
    chk("mtip_pre", 64'(irq_mtip), 64'd0);
    prev = mtime;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (irq_mtip) begin
        seen = 1'b1;
        chk("mtip_at", mtime, 64'h10);
        chk("mtip_prev", prev, 64'hF);
      end
      prev = mtime;
    end
    chk("mtip_seen", 64'(seen), 64'd1);
    access("cmphi1", c_base + 32'h4004, 1'b1, 32'h1, 4'hF, 32'h0, 1'b0, 0);
    chk("mtip_clr", 64'(irq_mtip), 64'd0);

    // Byte strobes
    access("cmplo_strb", c_base + 32'h4000, 1'b1, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 0);
    access("cmplo_rd", c_base + 32'h4000, 1'b0, 32'h0, 4'h0, 32'h00BB_00DD, 1'b0, 0);
    access("cmphi_rd", c_base + 32'h4004, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0, 0);

    // mtime wrap, write cycles do not increment
    access("mthi_ff", c_base + 32'hBFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 0);
    chk("mthi_snap", 64'(snap_accept[63:32]), 64'hFFFF_FFFF);
    access("mtlo_ff", c_base + 32'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 0);
    chk("mtlo_snap", snap_accept, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mt_wrap", snap_done, 64'd0);

    // Unmapped accesses
    access("unmap_rd", c_base + 32'h1000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    access("badbase_wr", 32'h0300_0000, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 0);
    access("badoff_wr", c_base + 32'h4, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 0);
    chk("msip_kept", 64'(irq_msip), 64'd1);
    access("msip_rd2", c_base, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0, 0);

    // Backpressure on MTIME lo read
    access("mtlo100", c_base + 32'hBFF8, 1'b1, 32'h100, 4'hF, 32'h0, 1'b0, 0);
    access("mtlo_hold", c_base + 32'hBFF8, 1'b0, 32'h0, 4'h0, 32'h101, 1'b0, 5);

    // SETSSIP pulse
    c0 = ssip_cnt;
    access("ssip_wr", c_base + 32'h8000, 1'b1, 32'h1, 4'h1, 32'h0, 1'b0, 2);
    chk("ssip_pulses", 64'(ssip_cnt - c0), 64'd1);
    c0 = ssip_cnt;
    access("ssip_rd", c_base + 32'h8000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 0);
    access("ssip_wr0", c_base + 32'h8000, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 0);
    chk("ssip_none", 64'(ssip_cnt - c0), 64'd0);
    access("msip_clr", c_base, 1'b1, 32'h0, 4'h1, 32'h0, 1'b0, 0);
    chk("msip_irq_clr", 64'(irq_msip), 64'd0);

    // Reset while a response is pending
    @(negedge clk);
    req_valid = 1'b1; req_addr = c_base + 32'h4000; req_write = 1'b0; req_strb = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("rr_pending", 64'(resp_valid), 64'd1);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("rr_async");
    @(negedge clk);
    chk_reset_outputs("rr_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_no_resp", 64'(resp_valid), 64'd0);
    end
    resp_ready = 1'b1;
    access("rr_cmphi", c_base + 32'h4004, 1'b0, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 0);
    access("rr_msip", c_base, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ladybird_aclint.md
LADYBIRD_ACLINT -- requirements
Module: ladybird_aclint

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default ACLINT_MSIP_BASE (32'h02000000), meaning the aperture base; upper 16 bits are matched.
REQ-002 The module SHALL have parameter TICK_DIV, default 1, meaning clk cycles per mtime increment (>=1).
REQ-003 One clock; reset is asynchronous and active-high. The ports SHALL be:
  clk  input  1  core clock
  rst  input  1  asynchronous active-high reset
  req_valid  input  1  request present
  req_ready  output  1  request accepted when high with req_valid
  req_addr  input  BUS_ADDR_W  byte address
  req_write  input  1  1 = write, 0 = read
  req_wdata  input  BUS_DATA_W  write data
  req_strb  input  BUS_DATA_W/8  byte enables
  resp_valid  output  1  response present
  resp_ready  input  1  response consumed when high with resp_valid
  resp_data  output  BUS_DATA_W  read data (0 for writes)
  resp_error  output  1  unmapped access
  irq_msip  output  1  machine software interrupt level
  irq_mtip  output  1  machine timer interrupt level
  irq_ssip_set  output  1  one-cycle supervisor software interrupt set pulse
  mtime  output  64  current mtime for the time CSR

Function
REQ-004 Registers (offset from BASE_ADDR): MSIP 0x0000 bit0; MTIMECMP lo/hi 0x4000/0x4004; SETSSIP 0x8000; MTIME lo/hi 0xBFF8/0xBFFC; req_addr[1:0] ignored.
REQ-005 FSM states IDLE and RESP; req_ready=1 only in IDLE.
REQ-006 IDLE->RESP on req_valid&&req_ready; read data and error SHALL be captured at acceptance.
REQ-007 In RESP resp_valid=1 with data held stable until resp_ready=1, then RESP->IDLE in that cycle's next edge; minimum latency 1 cycle, throughput one access per 2 cycles.
REQ-008 Writes SHALL update only bytes with req_strb set, effective on the acceptance edge.
REQ-009 MSIP write sets irq_msip from wdata[0] when strb[0]; bits [31:1] read as 0.
REQ-010 SETSSIP write with strb[0] and wdata[0]=1 SHALL drive irq_ssip_set high for exactly the first RESP cycle; SETSSIP reads return 0.
REQ-011 Prescaler counts 0..TICK_DIV-1; mtime increments by 1 on each prescaler wrap; 2^64-1 wraps to 0.
REQ-012 A write to MTIME lo or hi SHALL suppress the increment in that cycle; prescaler continues.
REQ-013 irq_mtip SHALL be (mtime >= mtimecmp) unsigned 64-bit, combinational from current register values.
REQ-014 Address with upper 16 bits not equal BASE_ADDR[31:16], or unlisted offset: read returns 0, write ignored, resp_error=1.
REQ-015 resp_error=0 for all mapped accesses; resp_data=0 for writes.

Reset
REQ-016 On rst: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_error=0, irq_msip=0, irq_ssip_set=0, mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF (irq_mtip=0).
REQ-017 Reset during RESP SHALL discard the pending response with no resp_valid after release.

Structure
REQ-018 Register offsets and ACLINT base constants SHALL live in ladybird_config; module uses BUS_ADDR_W/BUS_DATA_W from it.
REQ-019 Prescaler and 64-bit counter SHALL be sub-module ladybird_aclint_mtime (inputs: write enables/data/strb; output: mtime).

Verification
REQ-020 Write 0xFFFFFFFF strb 4'hF to 0x02000000, then read -> irq_msip=1, resp_data=0x00000001, resp_error=0.
REQ-021 TICK_DIV=1; write MTIMECMP lo=0x10, hi=0 -> irq_mtip rises on the cycle mtime reaches 0x10; writing MTIMECMP hi=1 clears it.
REQ-022 Write MTIME lo=0xFFFFFFFF, hi=0xFFFFFFFF -> mtime wraps to 0 after one tick; no increment in the write cycles.
REQ-023 Read 0x02001000 -> resp_data=0, resp_error=1; write 0x03000000 -> resp_error=1, no state change.
REQ-024 Hold resp_ready=0 for 5 cycles after read of MTIME lo -> resp_data constant, req_ready=0 throughout; SETSSIP write 1 -> irq_ssip_set high exactly one cycle.
REQ-025 Assert rst during RESP -> resp_valid=0, all outputs at REQ-016 values, next request handled normally.
